// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, clock polarity/phase helpers and the link state type.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module spi_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI target: MSB-first words in any SPI mode, one-entry transmit holding register,
// one-cycle receive strobe and status pulses.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned MODE       = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  irq,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam logic CPOL  = cpol(2'(MODE));
  localparam logic CPHA  = cpha(2'(MODE));
  localparam int   CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, ss_n_s, mosi_s;

  spi_sync_2ff #(.RST_VAL(CPOL)) u_sync_sclk (.clk_i(clk), .rst_ni(rst_n), .d_i(sclk), .q_o(sclk_s));
  spi_sync_2ff #(.RST_VAL(1'b1)) u_sync_ss   (.clk_i(clk), .rst_ni(rst_n), .d_i(ss_n), .q_o(ss_n_s));
  spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(clk), .rst_ni(rst_n), .d_i(mosi), .q_o(mosi_s));

  spi_state_e            state_q;
  logic                  sclk_prev_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_empty_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  miso_oe_q, busy_q, rx_valid_q, irq_q, tx_underrun_q, frame_abort_q;

  logic                  sclk_rise_s, sclk_fall_s, lead_s, trail_s, sample_edge_s, shift_edge_s;
  logic                  active_s, enter_s, do_sample_s, word_done_s, load_s, accept_s;
  logic [DATA_WIDTH-1:0] rx_shift_d, load_word_d;

  assign sclk_rise_s   = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s   = ~sclk_s & sclk_prev_q;
  assign lead_s        = CPOL ? sclk_fall_s : sclk_rise_s;
  assign trail_s       = CPOL ? sclk_rise_s : sclk_fall_s;
  assign sample_edge_s = CPHA ? trail_s : lead_s;
  assign shift_edge_s  = CPHA ? lead_s : trail_s;

  assign active_s    = (state_q == ST_ACTIVE);
  assign enter_s     = ~active_s & ~ss_n_s;
  assign do_sample_s = active_s & ~ss_n_s & sample_edge_s;
  assign word_done_s = do_sample_s & (bit_cnt_q == LAST_BIT);
  assign load_s      = enter_s | word_done_s;
  assign accept_s    = tx_valid & hold_empty_q;
  assign rx_shift_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  assign load_word_d = hold_empty_q ? '0 : hold_q;

  // Frame FSM, shift registers, holding register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sclk_prev_q   <= CPOL;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      hold_q        <= '0;
      hold_empty_q  <= 1'b1;
      rx_data_q     <= '0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      irq_q         <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sclk_prev_q   <= sclk_s;
      rx_valid_q    <= 1'b0;
      irq_q         <= 1'b0;
      frame_abort_q <= 1'b0;
      tx_underrun_q <= load_s & hold_empty_q;
      if (accept_s) begin
        hold_q <= tx_data;
      end
      // A load frees the holding slot; an accept in the same cycle refills it
      hold_empty_q <= (hold_empty_q | load_s) & ~accept_s;
      case (state_q)
        ST_IDLE: begin
          if (!ss_n_s) begin
            state_q    <= ST_ACTIVE;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= load_word_d;
          end
        end
        ST_ACTIVE: begin
          if (ss_n_s) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            frame_abort_q <= (bit_cnt_q != '0);
          end else if (do_sample_s) begin
            rx_shift_q <= rx_shift_d;
            if (word_done_s) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              irq_q      <= 1'b1;
              bit_cnt_q  <= '0;
              tx_shift_q <= load_word_d;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (shift_edge_s && (bit_cnt_q != '0)) begin
            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign miso        = miso_oe_q & tx_shift_q[DATA_WIDTH-1];
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = hold_empty_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign irq         = irq_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

Clocked SPI target that forms the opposite end of the team's `spi_master` link. It oversamples `sclk`, `ss_n` and `mosi` in the system clock domain and shifts `DATA_WIDTH`-bit words MSB-first in any of SPI modes 0–3. Received words are delivered with a one-cycle valid strobe. Transmit words come from a single-entry holding register fed by a valid/ready handshake. It sits in peripheral-side designs and in the verification environment as the `spi_master` counterpart.

## Interface
- `MODE`, 3: SPI mode; CPOL = `MODE[1]`, CPHA = `MODE[0]`.
- `DATA_WIDTH`, 32: bits per word; ≥ 2.
- `clk` in 1: system clock; f_clk ≥ 8 × f_sclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from master, asynchronous.
- `ss_n` in 1: this target's select, active-low, asynchronous.
- `mosi` in 1: serial data from master.
- `miso` out 1: serial data to master; 0 when `miso_oe` = 0.
- `miso_oe` out 1: output enable for the top-level tri-state; equals synchronized select.
- `tx_data` in DATA_WIDTH: next word to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: holding register empty.
- `rx_data` out DATA_WIDTH: last complete received word; holds until the next word completes.
- `rx_valid` out 1: one-cycle strobe when `rx_data` updates.
- `busy` out 1: frame in progress (state ACTIVE).
- `irq` out 1: one-cycle pulse, coincident with `rx_valid`.
- `tx_underrun` out 1: one-cycle pulse; a word was loaded while the holding register was empty.
- `frame_abort` out 1: one-cycle pulse; select deasserted mid-word.

## Operation
- **Synchronization:** `sclk`, `ss_n` and `mosi` each pass through a 2-FF synchronizer. `sclk` edges are detected from the synchronized value and its previous value.
- **Edge roles:** the leading edge is the idle→active transition (rising if CPOL = 0, falling if CPOL = 1).
  - sample edge = leading if CPHA = 0, trailing if CPHA = 1;
  - shift edge = the other edge.
- **States:** IDLE and ACTIVE.
  - IDLE → ACTIVE on synchronized `ss_n` = 0. On entry, `bit_cnt` = 0 and the word is loaded.
  - ACTIVE → IDLE on synchronized `ss_n` = 1.
- **Word load:**
  - If holding is full: tx shift register ← holding, holding marked empty.
  - Otherwise: tx shift register ← 0 and `tx_underrun` pulses.
- **Transmit:** `miso` = tx shift register MSB while `miso_oe` = 1.
- **Sample edge:** rx shift ← {rx shift[DATA_WIDTH-2:0], mosi_sync}; `bit_cnt`++.
  - When `bit_cnt` reaches DATA_WIDTH: `rx_data` ← complete word; `rx_valid` and `irq` pulse; `bit_cnt` ← 0; word load is performed in the same cycle.
- **Shift edge:** tx shift ← tx shift << 1, only when `bit_cnt` ≠ 0. This single rule covers CPHA 0 and 1 and continuous multi-word frames under one select.
- **Holding register:** accepts data when `tx_valid` & `tx_ready`; `tx_ready` = holding empty.
  - A same-cycle load and accept is allowed: the old word moves to the shift register and the new word enters holding.
- **Abort:** select deasserted with `bit_cnt` ≠ 0:
  - partial rx word discarded, no `rx_valid`, `frame_abort` pulses;
  - the already-loaded tx word is lost, and the holding register is untouched.
- **No backpressure on rx:** an unread `rx_data` is overwritten by the next word.

## Timing
- **Reset values:** state IDLE; `miso` 0, `miso_oe` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `busy` 0, `irq` 0, `tx_underrun` 0, `frame_abort` 0; shift registers and `bit_cnt` 0; holding empty.
- **Select latency:** 3 clk from `ss_n` fall to `miso_oe`/`busy` = 1 and first `miso` bit valid (2 sync + 1 register). Master must allow ≥ 4 clk from `ss_n` fall to the first `sclk` edge.
- **Shift latency:** `miso` changes 3 clk after the pin-level shift edge.
- **Sample latency:** sampled data is the `mosi` value synchronized alongside `sclk`, so it has the same latency as `sclk`.
- **Receive latency:** `rx_valid` is asserted 3 clk after the final pin-level sample edge.
- **Deselect latency:** `miso_oe`/`busy` fall 3 clk after `ss_n` rise.
- **Reset mid-frame:** immediate return to reset values; the next frame begins on the next select fall observed after `rst_n` = 1.

## Structure
- **Package `spi_pkg`:** mode encodings, functions `cpol(mode)`/`cpha(mode)`, and the state enumeration. Shared with `spi_master`.
- **Sub-module `spi_sync_2ff`:** single-bit, parameterized reset value. Instantiated for `sclk` (reset value CPOL), `ss_n` (reset value 1) and `mosi` (reset value 0).

## Test plan
- **Mode 3, 32-bit:** push `tx_data` 0x0000AA55; master sends 0x0000CCCC → `miso` stream 0x0000AA55 MSB-first; `rx_data` = 0x0000CCCC; one `rx_valid`/`irq` pulse; `tx_ready` rises 1 clk after select.
- **Modes 0, 1, 2:** same exchange with 0x12345678 / 0x87654321 → bit-exact both directions in each mode.
- **Underrun:** holding empty at select → `miso` all zeros; `tx_underrun` pulses once; reception unaffected.
- **Back-to-back words:** one select, 64 clocks, holding refilled after the first load → `rx_valid` twice (0x11111111, 0x22222222); second tx word shifted with no gap bit.
- **Abort:** deselect after 10 bits → no `rx_valid`; `frame_abort` pulse; next full frame correct.
- **Reset mid-frame:** assert `rst_n` = 0 after 16 bits → all outputs at reset values within the same cycle; the following frame is received correctly.
